// File: rtl/sram_access_scheduler_pkg.sv
// Shared parameters, types and state encodings for the SRAM access scheduler.
package sram_access_scheduler_pkg;

  localparam int unsigned WORD_W   = 256;  // SRAM word width
  localparam int unsigned ADDR_W   = 10;   // SRAM address width
  localparam int unsigned DEPTH    = 1024; // SRAM entries, 2**ADDR_W
  localparam int unsigned WQ_DEPTH = 4;    // PE write-back holding queue entries

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t FullCnt = cnt_t'(DEPTH);

  // Scheduler states (legacy-compatible constant encoding)
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

endpackage

// File: rtl/sram_access_scheduler_if.sv
// Bus bundle between the scheduler and its environment (control, loader, PE array, SRAM macro).
// slave  : scheduler side (i_* inputs, o_* outputs)
// master : environment side (drives i_*, observes o_*)
interface sram_access_scheduler_if;
  import sram_access_scheduler_pkg::*;

  // control / status
  logic  i_init;
  logic  o_busy;
  cnt_t  o_count;
  logic  o_err_ovf;
  // loader stream
  logic  i_ld_valid;
  word_t i_ld_data;
  logic  i_ld_last;
  logic  o_ld_ready;
  // PE read stream
  logic  i_pe_rd_req;
  word_t o_pe_rd_data;
  logic  o_pe_rd_valid;
  // PE write-back stream
  logic  i_pe_wr_valid;
  word_t i_pe_wr_data;
  logic  o_pe_wr_ready;
  // SRAM macro
  logic  o_sram_cen;
  logic  o_sram_wen;
  addr_t o_sram_a;
  word_t o_sram_d;
  word_t i_sram_q;

  modport slave (
    input  i_init, i_ld_valid, i_ld_data, i_ld_last, i_pe_rd_req, i_pe_wr_valid, i_pe_wr_data,
           i_sram_q,
    output o_busy, o_count, o_err_ovf, o_ld_ready, o_pe_rd_data, o_pe_rd_valid, o_pe_wr_ready,
           o_sram_cen, o_sram_wen, o_sram_a, o_sram_d
  );

  modport master (
    output i_init, i_ld_valid, i_ld_data, i_ld_last, i_pe_rd_req, i_pe_wr_valid, i_pe_wr_data,
           i_sram_q,
    input  o_busy, o_count, o_err_ovf, o_ld_ready, o_pe_rd_data, o_pe_rd_valid, o_pe_wr_ready,
           o_sram_cen, o_sram_wen, o_sram_a, o_sram_d
  );

endinterface

// File: rtl/sas_write_queue.sv
// Small synchronous FIFO holding PE write-back words until the SRAM port is free.
// Ports: clk/rst_n, flush_i (synchronous clear), push_i/data_i, pop_i, data_o (head word),
//        full_o, empty_o. Depth must be a power of 2, at least 2.
module sas_write_queue #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Extra MSB on each pointer distinguishes full from empty
  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic [PtrW:0]      ptr_one;

  assign ptr_one = {{PtrW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + ptr_one;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

endmodule

// File: rtl/sram_access_scheduler.sv
// Time-multiplexes one single-port SRAM between the T-sequence loader, PE reads and PE
// write-backs. The SRAM holds a circular word queue: loads and write-backs push at the tail,
// PE reads pop from the head. All SRAM pins are registered; at most one access per cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: init, loader, PE read/write
//        streams, SRAM macro pins, busy/count/overflow status).
module sram_access_scheduler
  import sram_access_scheduler_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  sram_access_scheduler_if.slave  bus
);

  logic [1:0] state_q, state_d;
  addr_t      head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_issue_q, rd_issue_d;
  logic       rd_valid_q, rd_valid_d;
  word_t      rd_data_q;
  logic       err_q, err_d;
  logic       cen_q, cen_d, wen_q, wen_d;
  addr_t      a_q, a_d;
  word_t      d_q, d_d;

  logic       ld_ready, wr_ready, rd_want, drain;
  logic       wq_push, wq_pop, wq_full, wq_empty;
  word_t      wq_data;

  assign ld_ready = (state_q == StLoad) && (count_q != FullCnt) && !bus.i_init;
  assign wr_ready = (state_q != StLoad) && !wq_full && !bus.i_init;
  assign wq_push  = bus.i_pe_wr_valid && wr_ready;
  // A fresh request can issue in the same cycle it arrives
  assign rd_want  = rd_pend_q || bus.i_pe_rd_req;

  sas_write_queue #(
    .Width (WORD_W),
    .Depth (WQ_DEPTH)
  ) u_wq (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.i_init),
    .push_i  (wq_push),
    .data_i  (bus.i_pe_wr_data),
    .pop_i   (wq_pop),
    .data_o  (wq_data),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_pend_d  = rd_pend_q;
    rd_issue_d = 1'b0;
    err_d      = err_q;
    cen_d      = 1'b1;
    wen_d      = 1'b1;
    a_d        = a_q;
    d_d        = d_q;
    wq_pop     = 1'b0;
    drain      = 1'b0;

    if (bus.i_init) begin
      state_d   = StLoad;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      rd_pend_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: state_d = StRun;
        StLoad: begin
          if (bus.i_ld_valid && ld_ready) begin
            cen_d   = 1'b0;
            wen_d   = 1'b0;
            a_d     = tail_q;
            d_d     = bus.i_ld_data;
            tail_d  = tail_q + addr_t'(1);
            count_d = count_q + cnt_t'(1);
            if (bus.i_ld_last) state_d = StRun;
          end
        end
        StRun: begin
          rd_pend_d = rd_want;
          // A full write queue would stall the PE, so it beats a pending read
          if (wq_full) begin
            drain = 1'b1;
          end else if (rd_want && (count_q != '0)) begin
            cen_d      = 1'b0;
            a_d        = head_q;
            head_d     = head_q + addr_t'(1);
            count_d    = count_q - cnt_t'(1);
            rd_issue_d = 1'b1;
            rd_pend_d  = 1'b0;
          end else if (!wq_empty) begin
            drain = 1'b1;
          end

          if (drain) begin
            wq_pop = 1'b1;
            // With the SRAM queue full the word is dropped and the overflow flag latches
            if (count_q == FullCnt) begin
              err_d = 1'b1;
            end else begin
              cen_d   = 1'b0;
              wen_d   = 1'b0;
              a_d     = tail_q;
              d_d     = wq_data;
              tail_d  = tail_q + addr_t'(1);
              count_d = count_q + cnt_t'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    rd_valid_d = rd_issue_q && !bus.i_init;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      rd_issue_q <= rd_issue_d;
      rd_valid_q <= rd_valid_d;
      if (rd_valid_q) rd_data_q <= bus.i_sram_q;
      err_q      <= err_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

  // SRAM data is valid in the strobe cycle; afterwards the captured copy is held
  assign bus.o_pe_rd_data  = rd_valid_q ? bus.i_sram_q : rd_data_q;
  assign bus.o_pe_rd_valid = rd_valid_q;
  assign bus.o_ld_ready    = ld_ready;
  assign bus.o_pe_wr_ready = wr_ready;
  assign bus.o_busy        = (state_q == StLoad);
  assign bus.o_count       = count_q;
  assign bus.o_err_ovf     = err_q;
  assign bus.o_sram_cen    = cen_q;
  assign bus.o_sram_wen    = wen_q;
  assign bus.o_sram_a      = a_q;
  assign bus.o_sram_d      = d_q;

endmodule

// File: tb/tb_sram_access_scheduler.sv
module tb_sram_access_scheduler;
  import sram_access_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_access_scheduler_if bus ();

  sram_access_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port SRAM, 1-cycle read latency
  word_t mem [DEPTH];
  word_t sram_q = '0;
  always @(posedge clk) begin
    if (!bus.o_sram_cen) begin
      if (!bus.o_sram_wen) mem[bus.o_sram_a] <= bus.o_sram_d;
      else                 sram_q <= mem[bus.o_sram_a];
    end
  end
  assign bus.i_sram_q = sram_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [WORD_W-1:0] got,
                     input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: logical queue contents ----------------
  int    mstate;         // 0 idle, 1 load, 2 run
  word_t store[$];       // words in the SRAM queue, oldest first
  word_t wq[$];          // write-backs waiting for the port
  int    head, tail;
  bit    pend, err;
  bit    e_cen, e_wen, e_issue, e_valid;
  int    e_a;
  word_t e_d, e_data, issued;

  task automatic model_reset();
    mstate = 0; store.delete(); wq.delete(); head = 0; tail = 0; pend = 0; err = 0;
    e_cen = 1; e_wen = 1; e_a = 0; e_d = '0; e_issue = 0; e_valid = 0; e_data = '0;
  endtask

  task automatic model_step(input bit ldr, input bit wrr);
    bit    n_cen, n_wen, n_issue, n_valid, drain, want;
    int    n_a;
    word_t n_d, n_data, w;
    n_cen = 1; n_wen = 1; n_issue = 0; drain = 0;
    n_a = e_a; n_d = e_d;
    n_valid = e_issue;
    n_data  = e_issue ? issued : e_data;
    if (bus.i_init) begin
      mstate = 1; store.delete(); wq.delete(); head = 0; tail = 0; pend = 0; err = 0;
      n_valid = 0; n_data = e_data;
    end else begin
      if (mstate == 0) begin
        mstate = 2;
      end else if (mstate == 1) begin
        if (bus.i_ld_valid && ldr) begin
          n_cen = 0; n_wen = 0; n_a = tail; n_d = bus.i_ld_data;
          store.push_back(bus.i_ld_data);
          tail = (tail + 1) % DEPTH;
          if (bus.i_ld_last) mstate = 2;
        end
      end else begin
        want = pend || bus.i_pe_rd_req;
        pend = want;
        if (wq.size() == WQ_DEPTH) drain = 1;
        else if (want && store.size() > 0) begin
          n_cen = 0; n_wen = 1; n_a = head;
          issued = store.pop_front();
          head = (head + 1) % DEPTH;
          n_issue = 1; pend = 0;
        end else if (wq.size() > 0) drain = 1;
        if (drain) begin
          w = wq.pop_front();
          if (store.size() == DEPTH) err = 1;
          else begin
            n_cen = 0; n_wen = 0; n_a = tail; n_d = w;
            store.push_back(w);
            tail = (tail + 1) % DEPTH;
          end
        end
      end
      if (bus.i_pe_wr_valid && wrr) wq.push_back(bus.i_pe_wr_data);
    end
    e_cen = n_cen; e_wen = n_wen; e_a = n_a; e_d = n_d;
    e_issue = n_issue; e_valid = n_valid; e_data = n_data;
  endtask

  // Per-cycle compare on the falling edge, then advance the model with this cycle's inputs
  always @(negedge clk) begin : cmp_p
    bit ldr, wrr;
    if (!rst_n) model_reset();
    ldr = (mstate == 1) && (store.size() < DEPTH) && !bus.i_init;
    wrr = (mstate != 1) && (wq.size() < WQ_DEPTH) && !bus.i_init;
    chk("sram_cen", bus.o_sram_cen, e_cen);
    chk("sram_wen", bus.o_sram_wen, e_wen);
    chk("sram_a", bus.o_sram_a, e_a);
    chk("sram_d", bus.o_sram_d, e_d);
    chk("count", bus.o_count, store.size());
    chk("busy", bus.o_busy, mstate == 1);
    chk("err_ovf", bus.o_err_ovf, err);
    chk("ld_ready", bus.o_ld_ready, ldr);
    chk("wr_ready", bus.o_pe_wr_ready, wrr);
    chk("rd_valid", bus.o_pe_rd_valid, e_valid);
    chk("rd_data", bus.o_pe_rd_data, e_data);
    if (rst_n) model_step(ldr, wrr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit got, saw_full;

  initial begin
    bus.i_init = 0; bus.i_ld_valid = 0; bus.i_ld_data = '0; bus.i_ld_last = 0;
    bus.i_pe_rd_req = 0; bus.i_pe_wr_valid = 0; bus.i_pe_wr_data = '0;
    rst_n = 0;
    repeat (3) cyc();
    #1;
    chk("rst_cen", bus.o_sram_cen, 1);
    chk("rst_count", bus.o_count, 0);
    chk("rst_wr_ready", bus.o_pe_wr_ready, 1);
    rst_n = 1;
    cyc(); cyc();

    // Reset in the middle of a load
    bus.i_init = 1; cyc(); bus.i_init = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.i_ld_valid = 1; bus.i_ld_data = word_t'(32'h10 + i); cyc();
    end
    bus.i_ld_valid = 0;
    #1 chk("midload_count", bus.o_count, 3);
    rst_n = 0;
    #1;
    chk("midrst_cen", bus.o_sram_cen, 1);
    chk("midrst_count", bus.o_count, 0);
    chk("midrst_busy", bus.o_busy, 0);
    cyc();
    #1 chk("midrst_cen_next", bus.o_sram_cen, 1);
    rst_n = 1;
    cyc(); cyc();

    // Load five words 1..5
    bus.i_init = 1; cyc(); bus.i_init = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.i_ld_valid = 1; bus.i_ld_data = word_t'(i); bus.i_ld_last = (i == 5); cyc();
    end
    bus.i_ld_valid = 0; bus.i_ld_last = 0;
    #1;
    chk("load_busy_fall", bus.o_busy, 0);
    chk("load_count", bus.o_count, 5);
    chk("load_last_a", bus.o_sram_a, 4);

    // Read latency: request N, issue N+1, strobe N+2
    bus.i_pe_rd_req = 1; cyc(); bus.i_pe_rd_req = 0;
    #1;
    chk("rd_issue_a", bus.o_sram_a, 0);
    chk("rd_issue_cen", bus.o_sram_cen, 0);
    cyc();
    #1;
    chk("rd_strobe", bus.o_pe_rd_valid, 1);
    chk("rd_word", bus.o_pe_rd_data, 1);
    chk("rd_count", bus.o_count, 4);

    // Empty the queue
    bus.i_pe_rd_req = 1; repeat (4) cyc(); bus.i_pe_rd_req = 0;
    repeat (3) cyc();
    #1 chk("empty_count", bus.o_count, 0);

    // Read pending on empty queue, satisfied by a write-back
    bus.i_pe_rd_req = 1; cyc(); bus.i_pe_rd_req = 0; cyc();
    bus.i_pe_wr_valid = 1; bus.i_pe_wr_data = word_t'(32'hAB); cyc(); bus.i_pe_wr_valid = 0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); #1;
      if (bus.o_pe_rd_valid) begin got = 1; break; end
    end
    chk("empty_rd_seen", got, 1);
    chk("empty_rd_data", bus.o_pe_rd_data, 32'hAB);

    // Write queue fills while reads compete
    saw_full = 0;
    bus.i_pe_rd_req = 1; bus.i_pe_wr_valid = 1;
    for (int k = 0; k < 14; k++) begin
      bus.i_pe_wr_data = word_t'(32'h100 + k);
      cyc();
      if (!bus.o_pe_wr_ready) saw_full = 1;
    end
    bus.i_pe_wr_valid = 0;
    repeat (10) cyc();
    bus.i_pe_rd_req = 0;
    repeat (10) cyc();
    chk("wq_full_seen", saw_full, 1);

    // Fill all DEPTH entries, then overflow with a write-back
    bus.i_init = 1; cyc(); bus.i_init = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_ld_valid = 1; bus.i_ld_data = word_t'(32'h1000 + i);
      bus.i_ld_last = (i == DEPTH - 1); cyc();
    end
    bus.i_ld_valid = 0; bus.i_ld_last = 0;
    #1;
    chk("fill_count", bus.o_count, 1024);
    chk("fill_last_a", bus.o_sram_a, 1023);
    bus.i_pe_wr_valid = 1; bus.i_pe_wr_data = word_t'(32'hCD); cyc(); bus.i_pe_wr_valid = 0;
    repeat (3) cyc();
    #1;
    chk("ovf_flag", bus.o_err_ovf, 1);
    chk("ovf_count", bus.o_count, 1024);

    // Head wraps from entry 0 after the fill; tail has wrapped to 0
    bus.i_pe_rd_req = 1; cyc(); bus.i_pe_rd_req = 0; cyc();
    #1;
    chk("wrap_rd_valid", bus.o_pe_rd_valid, 1);
    chk("wrap_rd_data", bus.o_pe_rd_data, 32'h1000);
    bus.i_pe_wr_valid = 1; bus.i_pe_wr_data = word_t'(32'hEE); cyc(); bus.i_pe_wr_valid = 0;
    cyc();
    #1;
    chk("wrap_wr_a", bus.o_sram_a, 0);
    chk("wrap_wr_wen", bus.o_sram_wen, 0);
    chk("wrap_count", bus.o_count, 1024);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
